// File: rtl/field_sequencer_pkg.sv
// Shared definitions for the field-level timing stage and the line stage:
// line class encodings, DAC level codes and default timing constants.
package field_sequencer_pkg;

  // Line classification as presented to the line stage.
  typedef enum logic [1:0] {
    LT_ACTIVE = 2'd0,
    LT_BLANK  = 2'd1,
    LT_EQ     = 2'd2,
    LT_VSYNC  = 2'd3
  } line_type_e;

  // DAC codes used while the field stage overrides the line stage.
  localparam logic [7:0] SYNC_LEVEL  = 8'd0;
  localparam logic [7:0] BLANK_LEVEL = 8'd57;

  // Default NTSC non-interlaced timing.
  localparam int LINE_CLKS_DEF    = 3176;
  localparam int HALF_CLKS_DEF    = 1588;
  localparam int EQ_PULSE_DEF     = 117;
  localparam int BROAD_PULSE_DEF  = 1355;
  localparam int LINES_DEF        = 262;
  localparam int FIRST_ACTIVE_DEF = 21;
  localparam int ACTIVE_LINES_DEF = 240;

  // Classify a 1-based line number. Lines 1-9 form the fixed vertical
  // interval (EQ, VSYNC, EQ in groups of three); the rest is blank except
  // for the active window.
  function automatic line_type_e classify_line(input logic [8:0] line,
                                               input int first_active,
                                               input int active_lines);
    line_type_e t;
    if (line <= 9'd3) begin
      t = LT_EQ;
    end else if (line <= 9'd6) begin
      t = LT_VSYNC;
    end else if (line <= 9'd9) begin
      t = LT_EQ;
    end else if (int'(line) < first_active) begin
      t = LT_BLANK;
    end else if (int'(line) < (first_active + active_lines)) begin
      t = LT_ACTIVE;
    end else begin
      t = LT_BLANK;
    end
    return t;
  endfunction

endpackage

// File: rtl/field_sequencer_if.sv
// Strobe input and field-timing outputs between the field stage and its
// neighbours. The driver of enable/line_start uses master; the field stage
// uses slave.
interface field_sequencer_if;
  import field_sequencer_pkg::*;

  logic       enable;
  logic       line_start;
  logic [8:0] line_num;
  line_type_e line_type;
  logic [7:0] active_row;
  logic       row_valid;
  logic       field_start;
  logic       override;
  logic [7:0] vlevel;
  logic       timeout;

  modport master (
    output enable, line_start,
    input  line_num, line_type, active_row, row_valid, field_start,
           override, vlevel, timeout
  );

  modport slave (
    input  enable, line_start,
    output line_num, line_type, active_row, row_valid, field_start,
           override, vlevel, timeout
  );

endinterface

// File: rtl/field_sequencer_vsync_pulse_gen.sv
// Vertical-interval pulse generator: folds the line position into a
// half-line position and emits the equalizing / serration sync pattern as
// a registered DAC override. Inputs are the next-cycle hc and line class so
// the registered output lines up with them.
module vsync_pulse_gen
  import field_sequencer_pkg::*;
#(
  parameter int HC_W        = 12,
  parameter int HALF_CLKS   = HALF_CLKS_DEF,
  parameter int EQ_PULSE    = EQ_PULSE_DEF,
  parameter int BROAD_PULSE = BROAD_PULSE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [HC_W-1:0] hc_i,
  input  line_type_e      line_type_i,
  output logic [7:0]      vlevel_o,
  output logic            override_o
);

  localparam logic [HC_W-1:0] HALF_L  = HC_W'(HALF_CLKS);
  localparam logic [HC_W-1:0] EQ_L    = HC_W'(EQ_PULSE);
  localparam logic [HC_W-1:0] BROAD_L = HC_W'(BROAD_PULSE);

  logic [HC_W-1:0] ph_s;
  logic [7:0]      vlevel_d;
  logic [7:0]      vlevel_q;
  logic            override_d;
  logic            override_q;

  // Position within the half-line; hc never exceeds two half-lines so one
  // conditional subtraction is enough.
  always_comb begin
    ph_s = hc_i;
    if (hc_i >= HALF_L) begin
      ph_s = hc_i - HALF_L;
    end else begin
      ph_s = hc_i;
    end
  end

  // Select sync or blank level from line class and half-line position.
  always_comb begin
    vlevel_d   = BLANK_LEVEL;
    override_d = 1'b0;
    case (line_type_i)
      LT_EQ: begin
        override_d = 1'b1;
        if (ph_s < EQ_L) begin
          vlevel_d = SYNC_LEVEL;
        end else begin
          vlevel_d = BLANK_LEVEL;
        end
      end
      LT_VSYNC: begin
        override_d = 1'b1;
        if (ph_s < BROAD_L) begin
          vlevel_d = SYNC_LEVEL;
        end else begin
          vlevel_d = BLANK_LEVEL;
        end
      end
      default: begin
        vlevel_d   = BLANK_LEVEL;
        override_d = 1'b0;
      end
    endcase
  end

  // Register the override so it changes together with the line class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vlevel_q   <= BLANK_LEVEL;
      override_q <= 1'b0;
    end else begin
      vlevel_q   <= vlevel_d;
      override_q <= override_d;
    end
  end

  assign vlevel_o   = vlevel_q;
  assign override_o = override_q;

endmodule

// File: rtl/field_sequencer.sv
// Field-level timing stage: counts line_start strobes into a field,
// classifies each line, tracks position within the line and flags a
// missing line_start. The vertical sync pattern comes from vsync_pulse_gen.
module field_sequencer
  import field_sequencer_pkg::*;
#(
  parameter int LINE_CLKS    = LINE_CLKS_DEF,
  parameter int HALF_CLKS    = HALF_CLKS_DEF,
  parameter int EQ_PULSE     = EQ_PULSE_DEF,
  parameter int BROAD_PULSE  = BROAD_PULSE_DEF,
  parameter int LINES        = LINES_DEF,
  parameter int FIRST_ACTIVE = FIRST_ACTIVE_DEF,
  parameter int ACTIVE_LINES = ACTIVE_LINES_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  field_sequencer_if.slave bus
);

  localparam int              HC_W    = $clog2(LINE_CLKS);
  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(LINE_CLKS - 1);
  localparam logic [8:0]      LINES_L = 9'(LINES);
  localparam logic [8:0]      FIRST_L = 9'(FIRST_ACTIVE);

  logic [1:0]      rst_sync_q;
  logic            rst_n_s;
  logic            accept_s;

  logic [8:0]      line_num_q, line_num_d;
  logic [HC_W-1:0] hc_q, hc_d;
  logic            armed_q, armed_d;
  logic            timeout_q, timeout_d;
  line_type_e      line_type_q, line_type_d;
  logic [7:0]      active_row_q, active_row_d;
  logic            row_valid_q, row_valid_d;
  logic            field_start_q, field_start_d;

  // Reset asserts asynchronously and releases two clocks later in step with clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_s  = rst_sync_q[1];
  assign accept_s = bus.enable & bus.line_start;

  // Line counter, position counter and field-start pulse; all frozen while disabled.
  always_comb begin
    line_num_d    = line_num_q;
    hc_d          = hc_q;
    field_start_d = 1'b0;
    armed_d       = armed_q;
    if (accept_s) begin
      hc_d    = '0;
      armed_d = 1'b1;
      if (line_num_q >= LINES_L) begin
        line_num_d    = 9'd1;
        field_start_d = 1'b1;
      end else begin
        line_num_d    = line_num_q + 9'd1;
        field_start_d = 1'b0;
      end
    end else if (bus.enable) begin
      if (hc_q < HC_MAX) begin
        hc_d = hc_q + HC_W'(1);
      end else begin
        hc_d = hc_q;
      end
    end else begin
      hc_d = hc_q;
    end
  end

  // Sticky timeout; armed by the first accepted strobe so the idle period
  // after reset does not count as a missing line.
  always_comb begin
    timeout_d = timeout_q;
    if (bus.enable && !bus.line_start && armed_q && (hc_q == HC_MAX)) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // Classify the line that will be current after this edge.
  always_comb begin
    line_type_d  = LT_BLANK;
    row_valid_d  = 1'b0;
    active_row_d = 8'd0;
    if (bus.enable) begin
      line_type_d = classify_line(line_num_d, FIRST_ACTIVE, ACTIVE_LINES);
      if (line_type_d == LT_ACTIVE) begin
        row_valid_d  = 1'b1;
        active_row_d = 8'(line_num_d - FIRST_L);
      end else begin
        row_valid_d  = 1'b0;
        active_row_d = 8'd0;
      end
    end else begin
      line_type_d  = LT_BLANK;
      row_valid_d  = 1'b0;
      active_row_d = 8'd0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      line_num_q    <= LINES_L;
      hc_q          <= HC_MAX;
      armed_q       <= 1'b0;
      timeout_q     <= 1'b0;
      line_type_q   <= LT_BLANK;
      active_row_q  <= 8'd0;
      row_valid_q   <= 1'b0;
      field_start_q <= 1'b0;
    end else begin
      line_num_q    <= line_num_d;
      hc_q          <= hc_d;
      armed_q       <= armed_d;
      timeout_q     <= timeout_d;
      line_type_q   <= line_type_d;
      active_row_q  <= active_row_d;
      row_valid_q   <= row_valid_d;
      field_start_q <= field_start_d;
    end
  end

  vsync_pulse_gen #(
    .HC_W        (HC_W),
    .HALF_CLKS   (HALF_CLKS),
    .EQ_PULSE    (EQ_PULSE),
    .BROAD_PULSE (BROAD_PULSE)
  ) u_pulse (
    .clk         (clk),
    .rst_n       (rst_n_s),
    .hc_i        (hc_d),
    .line_type_i (line_type_d),
    .vlevel_o    (bus.vlevel),
    .override_o  (bus.override)
  );

  assign bus.line_num    = line_num_q;
  assign bus.line_type   = line_type_q;
  assign bus.active_row  = active_row_q;
  assign bus.row_valid   = row_valid_q;
  assign bus.field_start = field_start_q;
  assign bus.timeout     = timeout_q;

endmodule
